// File: rtl/axi_read_responder.sv
// Single-outstanding AXI4 read responder backed by a 64-bit SRAM.
// One beat at a time: READ issues the SRAM read, LOAD captures it, DATA presents it.
module axi_read_responder #(
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int unsigned DEPTH   = 4096,
    parameter int unsigned LATENCY = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    output logic        rvalid,
    input  logic        rready,
    output logic [63:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic [3:0]  rid,
    output logic        mem_ren,
    output logic [31:0] mem_raddr,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        READ,
        LOAD,
        DATA
    } state_e;

    localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(DEPTH) * 33'd8;
    localparam logic [3:0]  WAIT_INIT = 4'((LATENCY == 0) ? 0 : LATENCY - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  id_q, id_d;
    logic [7:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;
    logic        slverr_q, slverr_d;
    logic [7:0]  beat_q, beat_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [63:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;
    logic [3:0]  rid_q, rid_d;

    logic [31:0] step;
    logic [31:0] win_mask;
    logic [31:0] next_addr;
    logic [31:0] off;
    logic        in_range;
    logic        beat_ok;
    logic        ar_bad;

    assign rdata = rdata_q;
    assign rresp = rresp_q;
    assign rlast = rlast_q;
    assign rid   = rid_q;

    // Per-beat address arithmetic, range decode and request legality.
    always_comb begin
        step     = 32'd1 << size_q;
        win_mask = ((32'(len_q) + 32'd1) << size_q) - 32'd1;
        case (burst_q)
            2'b01:   next_addr = addr_q + step;
            2'b10:   next_addr = (addr_q & ~win_mask)
                               | ((addr_q + step) & win_mask);
            default: next_addr = addr_q;
        endcase
        off      = addr_q - BASE;
        in_range = ({1'b0, addr_q} >= {1'b0, BASE})
                && ({1'b0, addr_q} < LIMIT);
        beat_ok  = in_range && !slverr_q;
        ar_bad   = (arsize > 3'd3)
                || (arburst == 2'b11)
                || ((arburst == 2'b10)
                    && !((arlen == 8'd1) || (arlen == 8'd3)
                      || (arlen == 8'd7) || (arlen == 8'd15)));
    end

    // Next-state and output decode of the burst FSM.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        id_d      = id_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        slverr_d  = slverr_q;
        beat_d    = beat_q;
        wcnt_d    = wcnt_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        arready   = 1'b0;
        rvalid    = 1'b0;
        mem_ren   = 1'b0;
        mem_raddr = 32'd0;
        case (state_q)
            IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    addr_d   = araddr;
                    id_d     = arid;
                    len_d    = arlen;
                    size_d   = arsize;
                    burst_d  = arburst;
                    slverr_d = ar_bad;
                    beat_d   = 8'd0;
                    wcnt_d   = WAIT_INIT;
                    state_d  = (LATENCY > 0) ? WAIT : READ;
                end
            end
            WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d = READ;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            READ: begin
                mem_ren   = beat_ok;
                mem_raddr = beat_ok ? (off >> 3) : 32'd0;
                state_d   = LOAD;
            end
            LOAD: begin
                rdata_d = beat_ok ? mem_rdata : 64'd0;
                if (slverr_q) begin
                    rresp_d = RESP_SLVERR;
                end else if (!in_range) begin
                    rresp_d = RESP_DECERR;
                end else begin
                    rresp_d = RESP_OKAY;
                end
                rlast_d = (beat_q == len_q);
                rid_d   = id_q;
                state_d = DATA;
            end
            DATA: begin
                rvalid = 1'b1;
                if (rready) begin
                    if (rlast_q) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = next_addr;
                        beat_d  = beat_q + 8'd1;
                        state_d = READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= 32'd0;
            id_q     <= 4'd0;
            len_q    <= 8'd0;
            size_q   <= 3'd0;
            burst_q  <= 2'd0;
            slverr_q <= 1'b0;
            beat_q   <= 8'd0;
            wcnt_q   <= 4'd0;
            rdata_q  <= 64'd0;
            rresp_q  <= 2'd0;
            rlast_q  <= 1'b0;
            rid_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            id_q     <= id_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            slverr_q <= slverr_d;
            beat_q   <= beat_d;
            wcnt_q   <= wcnt_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
            rid_q    <= rid_d;
        end
    end

endmodule

// File: tb/tb_axi_read_responder.sv
// Bench for axi_read_responder: two instances (LATENCY 0 and 4) checked
// every cycle against a transaction-level model of the read channel.
module tb_axi_read_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]  arvalid, arready, rvalid, rready, rlast, mem_ren;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [63:0] rdata     [2];
    logic [1:0]  rresp     [2];
    logic [3:0]  rid       [2];
    logic [31:0] mem_raddr [2];
    logic [63:0] mem_rdata [2];

    axi_read_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(0)) u0 (
        .clock(clk), .reset(rst_n),
        .arvalid(arvalid[0]), .arready(arready[0]), .araddr(araddr),
        .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid[0]), .rready(rready[0]), .rdata(rdata[0]),
        .rresp(rresp[0]), .rlast(rlast[0]), .rid(rid[0]),
        .mem_ren(mem_ren[0]), .mem_raddr(mem_raddr[0]),
        .mem_rdata(mem_rdata[0])
    );

    axi_read_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(4)) u1 (
        .clock(clk), .reset(rst_n),
        .arvalid(arvalid[1]), .arready(arready[1]), .araddr(araddr),
        .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid[1]), .rready(rready[1]), .rdata(rdata[1]),
        .rresp(rresp[1]), .rlast(rlast[1]), .rid(rid[1]),
        .mem_ren(mem_ren[1]), .mem_raddr(mem_raddr[1]),
        .mem_rdata(mem_rdata[1])
    );

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic [3:0]  id;
        logic        last;
        logic        ren;
        logic [31:0] widx;
    } beat_t;

    logic [63:0] mem [DEPTH];
    beat_t       expq[$];
    logic [63:0] beat_log[$];
    logic [1:0]  resp_log[$];
    logic        last_log[$];
    logic [31:0] ren_log[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_en = 0;
    bit busy [2];
    int due  [2];
    int rdc  [2];
    int hs   [2];
    int lat_meas [2];
    bit prev_rv [2];

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : 4;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Expected beats of the burst on the AR lines, from the protocol rules.
    function automatic void push_burst();
        logic [31:0] a;
        longint      sz, win, wb;
        bit          slv, dec;
        beat_t       b;
        a   = araddr;
        sz  = longint'(1) << arsize;
        win = (longint'(arlen) + 1) * sz;
        slv = (arsize > 3) || (arburst == 2'b11)
           || (arburst == 2'b10 && !(arlen == 1 || arlen == 3
                                  || arlen == 7 || arlen == 15));
        for (int i = 0; i <= int'(arlen); i++) begin
            dec    = (longint'(a) < longint'(BASE))
                  || (longint'(a) >= longint'(BASE) + DEPTH * 8);
            b.resp = slv ? 2'b10 : (dec ? 2'b11 : 2'b00);
            b.ren  = (b.resp == 2'b00);
            b.widx = (a - BASE) / 8;
            b.data = b.ren ? mem[b.widx] : 64'd0;
            b.id   = arid;
            b.last = (i == int'(arlen));
            expq.push_back(b);
            if (arburst == 2'b01) begin
                a = a + 32'(sz);
            end else if (arburst == 2'b10 && !slv) begin
                wb = longint'(a) - longint'(a) % win;
                a  = 32'(wb + (longint'(a) - wb + sz) % win);
            end
        end
    endfunction

    // SRAM: data the cycle after a read, junk otherwise.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_ren[d] && mem_raddr[d] < DEPTH)
                mem_rdata[d] <= mem[mem_raddr[d]];
            else
                mem_rdata[d] <= {$urandom, $urandom};
        end
    end

    // Model timeline: handshakes decided by the model's own expectations.
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                busy[d] = 0;
            end else if (arvalid[d] && !busy[d]) begin
                busy[d] = 1;
                hs[d]   = cyc;
                due[d]  = cyc + 3 + lat_of(d);
                rdc[d]  = cyc + 1 + lat_of(d);
                push_burst();
            end else if (busy[d] && rready[d] && cyc >= due[d]
                         && expq.size() > 0) begin
                beat_log.push_back(rdata[d]);
                resp_log.push_back(rresp[d]);
                last_log.push_back(rlast[d]);
                if (expq[0].last) begin
                    busy[d] = 0;
                end else begin
                    due[d] = cyc + 3;
                    rdc[d] = cyc + 1;
                end
                void'(expq.pop_front());
            end
        end
        if (!rst_n) expq.delete();
    end

    // Compare process: every cycle, both instances, against the model.
    int cur;
    bit ev, er;
    always @(negedge clk) begin
        if (chk_en) begin
            cur = cyc + 1;
            for (int d = 0; d < 2; d++) begin
                ev = busy[d] && cur >= due[d];
                er = busy[d] && cur == rdc[d] && expq.size() > 0
                  && expq[0].ren;
                check("arready", 64'(arready[d]), 64'(!busy[d]));
                check("rvalid", 64'(rvalid[d]), 64'(ev));
                check("mem_ren", 64'(mem_ren[d]), 64'(er));
                if (er)
                    check("mem_raddr", 64'(mem_raddr[d]), 64'(expq[0].widx));
                if (ev && rvalid[d] && expq.size() > 0) begin
                    check("rdata", rdata[d], expq[0].data);
                    check("rresp", 64'(rresp[d]), 64'(expq[0].resp));
                    check("rid", 64'(rid[d]), 64'(expq[0].id));
                    check("rlast", 64'(rlast[d]), 64'(expq[0].last));
                end
                if (mem_ren[d]) ren_log.push_back(mem_raddr[d]);
                if (rvalid[d] && !prev_rv[d]) lat_meas[d] = cur - hs[d];
                prev_rv[d] = rvalid[d];
            end
        end
    end

    task automatic clear_logs();
        beat_log.delete();
        resp_log.delete();
        last_log.delete();
        ren_log.delete();
    endtask

    task automatic issue(input int d, input logic [31:0] a,
                         input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bt);
        araddr     = a;
        arid       = id;
        arlen      = len;
        arsize     = sz;
        arburst    = bt;
        arvalid[d] = 1'b1;
        @(negedge clk);
        arvalid[d] = 1'b0;
    endtask

    // mode 0: rready high, 1: toggle, 2: random with stray arvalid.
    task automatic drain(input int d, input int mode);
        int t;
        t = 0;
        while (busy[d] && t < 3000) begin
            case (mode)
                0:       rready[d] = 1'b1;
                1:       rready[d] = ~rready[d];
                default: begin
                    rready[d]  = ($urandom_range(0, 2) != 0);
                    arvalid[d] = $urandom_range(0, 1) == 1;
                end
            endcase
            @(negedge clk);
            t++;
        end
        arvalid[d] = 1'b0;
        rready[d]  = 1'b0;
        check("burst_done", 64'(busy[d]), 64'd0);
    endtask

    initial begin
        int t;
        logic [31:0] a;
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
        mem[1]  = 64'hDEAD_BEEF_0123_4567;
        rst_n   = 1'b0;
        arvalid = '0;
        rready  = '0;
        araddr  = '0;
        arid    = '0;
        arlen   = '0;
        arsize  = '0;
        arburst = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_rvalid", 64'(rvalid[d]), 64'd0);
            check("rst_arready", 64'(arready[d]), 64'd1);
            check("rst_rdata", rdata[d], 64'd0);
            check("rst_mem_ren", 64'(mem_ren[d]), 64'd0);
        end
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Single beat, zero latency.
        clear_logs();
        issue(0, BASE + 8, 4'd5, 8'd0, 3'd3, 2'b01);
        drain(0, 0);
        check("arready_after", 64'(arready[0]), 64'd1);
        check("single_lat", 64'(lat_meas[0]), 64'd3);
        check("single_data", beat_log[0], 64'hDEAD_BEEF_0123_4567);
        check("single_resp", 64'(resp_log[0]), 64'd0);
        check("single_last", 64'(last_log[0]), 64'd1);

        // INCR four beats with rready toggling.
        clear_logs();
        issue(0, BASE, 4'd3, 8'd3, 3'd3, 2'b01);
        drain(0, 1);
        check("incr_beats", 64'(beat_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("incr_raddr", 64'(ren_log[i]), 64'(i));
            check("incr_last", 64'(last_log[i]), 64'(i == 3));
        end

        // WRAP legal and illegal length.
        clear_logs();
        issue(0, BASE + 16, 4'd7, 8'd3, 3'd3, 2'b10);
        drain(0, 0);
        check("wrap_w0", 64'(ren_log[0]), 64'd2);
        check("wrap_w1", 64'(ren_log[1]), 64'd3);
        check("wrap_w2", 64'(ren_log[2]), 64'd0);
        check("wrap_w3", 64'(ren_log[3]), 64'd1);
        clear_logs();
        issue(0, BASE, 4'd1, 8'd2, 3'd3, 2'b10);
        drain(0, 0);
        check("wrap3_beats", 64'(beat_log.size()), 64'd3);
        check("wrap3_noren", 64'(ren_log.size()), 64'd0);
        for (int i = 0; i < 3; i++)
            check("wrap3_resp", 64'(resp_log[i]), 64'd2);

        // Crossing the top of memory.
        clear_logs();
        issue(0, BASE + DEPTH * 8 - 8, 4'd9, 8'd1, 3'd3, 2'b01);
        drain(0, 0);
        check("edge_resp0", 64'(resp_log[0]), 64'd0);
        check("edge_data0", beat_log[0], mem[DEPTH - 1]);
        check("edge_resp1", 64'(resp_log[1]), 64'd3);
        check("edge_data1", beat_log[1], 64'd0);
        check("edge_last1", 64'(last_log[1]), 64'd1);

        // Randomized bursts on both instances.
        for (int n = 0; n < 80; n++) begin
            int d;
            d = n % 2;
            a = BASE - 32'd64 + 32'($urandom_range(0, DEPTH * 8 + 128));
            if ($urandom_range(0, 1) == 1) a[2:0] = 3'd0;
            issue(d, a, 4'($urandom), 8'($urandom_range(0, 15)),
                  3'($urandom_range(0, 4)), 2'($urandom));
            drain(d, 2);
        end

        // Latency 4, then reset while a beat is pending.
        clear_logs();
        issue(1, BASE, 4'd2, 8'd0, 3'd3, 2'b01);
        t = 0;
        while (!rvalid[1] && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("lat4_first", 64'(lat_meas[1]), 64'd7);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_rvalid1", 64'(rvalid[1]), 64'd0);
        check("rst_rdata1", rdata[1], 64'd0);
        check("rst_rid1", 64'(rid[1]), 64'd0);
        check("rst_rlast1", 64'(rlast[1]), 64'd0);
        check("rst_rresp1", 64'(rresp[1]), 64'd0);
        check("rst_ren1", 64'(mem_ren[1]), 64'd0);
        check("rst_raddr1", 64'(mem_raddr[1]), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_arready1", 64'(arready[1]), 64'd1);
        rready[1] = 1'b1;
        repeat (10) @(negedge clk);
        check("abandoned", 64'(beat_log.size()), 64'd0);
        rready[1] = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
